button_event_encoder: RTL and testbench

//  Parametrised successor to the board push-button encoder. Synchronises and debounces
//  NUM_BTNS raw buttons and priority-encodes the debounced state (lowest index wins).

---
 rtl/button_event_encoder.sv | 165 ++++++++++++++++
 tb/tb_button_event_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_encoder.sv
// Push-button front end: synchronise, debounce and priority-encode the buttons,
// then emit press events and optional auto-repeat events while a button is held.
module button_event_encoder #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    localparam int CODE_W         = $clog2(NUM_BTNS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_stable,
    output logic [CODE_W-1:0]   btn_code,
    output logic                evt_valid,
    output logic [CODE_W-1:0]   evt_code,
    output logic                evt_repeat
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int R_W   = $clog2(R_MAX);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [R_W-1:0]  RD_LAST = R_W'(REPEAT_DELAY - 1);
    localparam logic [R_W-1:0]  RP_LAST = R_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [NUM_BTNS-1:0] meta;
    logic [NUM_BTNS-1:0] sync;
    logic [NUM_BTNS-1:0] stable_q;
    logic [DB_W-1:0]     cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0] new_btn;
    logic                press;
    logic [CODE_W-1:0]   press_code;

    state_t              state, state_d;
    logic [R_W-1:0]      rcnt, rcnt_d;
    logic [CODE_W-1:0]   trk, trk_d;
    logic                rpt_due;
    logic                evt_d;
    logic                evt_rep_d;
    logic [CODE_W-1:0]   evt_code_d;

    // Lowest set index wins; code is index+1 so that 0 means "nothing".
    function automatic logic [CODE_W-1:0] prio(input logic [NUM_BTNS-1:0] v);
        prio = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) prio = CODE_W'(i + 1);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable <= '0;
            stable_q   <= '0;
            for (int i = 0; i < NUM_BTNS; i++) cnt[i] <= '0;
        end else begin
            stable_q <= btn_stable;
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync[i] == btn_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    btn_stable[i] <= sync[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_code   = prio(btn_stable);
    assign new_btn    = btn_stable & ~stable_q;
    assign press      = |new_btn;
    assign press_code = prio(new_btn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
            trk   <= '0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
            trk   <= trk_d;
        end
    end

    // A new press always wins over a tracked button that lost priority or a due repeat.
    always_comb begin
        state_d = state;
        rcnt_d  = rcnt;
        trk_d   = trk;
        rpt_due = 1'b0;
        if (press) begin
            state_d = DELAY;
            rcnt_d  = '0;
            trk_d   = press_code;
        end else begin
            unique case (state)
                IDLE: ;
                DELAY: begin
                    if (btn_code != trk) begin
                        state_d = IDLE;
                    end else if (rcnt == RD_LAST) begin
                        rpt_due = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (btn_code != trk) begin
                        state_d = IDLE;
                    end else if (rcnt == RP_LAST) begin
                        rpt_due = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (REPEAT_EN == 0) begin
            state_d = IDLE;
            rpt_due = 1'b0;
        end
    end

    always_comb begin
        evt_d      = press | rpt_due;
        evt_rep_d  = ~press;
        evt_code_d = press ? press_code : trk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_repeat <= 1'b0;
        end else begin
            evt_valid <= evt_d;
            if (evt_d) begin
                evt_code   <= evt_code_d;
                evt_repeat <= evt_rep_d;
            end
        end
    end

endmodule

// File: tb/tb_button_event_encoder.sv
// Bench for button_event_encoder: directed scenarios plus random button traffic,
// checked every cycle against a time-based reference model.
module tb_button_event_encoder;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;

    logic [NB-1:0] st0, st1;
    logic [CW-1:0] bc0, bc1, ec0, ec1;
    logic          v0, v1, r0, r1;

    button_event_encoder #(
        .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_stable(st0), .btn_code(bc0), .evt_valid(v0),
        .evt_code(ec0), .evt_repeat(r0)
    );

    button_event_encoder #(
        .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_norep (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_stable(st1), .btn_code(bc1), .evt_valid(v1),
        .evt_code(ec1), .evt_repeat(r1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: history window for debounce, press timestamps for repeats.
    logic [NB-1:0] m_r1, m_r2, m_st, m_stq;
    logic [NB-1:0] m_hist [DC];
    int            t = 0;
    bit            m_act [2];
    int            m_trk [2];
    int            m_pt  [2];
    bit            m_v   [2];
    bit            m_rep [2];
    int            m_ec  [2];
    int            ev [2];
    int            rp [2];

    function automatic int pcode(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_r1 = '0; m_r2 = '0; m_st = '0; m_stq = '0;
        for (int j = 0; j < DC; j++) m_hist[j] = '0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_trk[k] = 0; m_pt[k] = 0;
            m_v[k] = 0; m_rep[k] = 0; m_ec[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] nw, ns;
        int d;
        bit all_diff;
        t++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nw = m_st & ~m_stq;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0;
            if (nw != 0) begin
                m_v[k] = 1; m_rep[k] = 0; m_ec[k] = pcode(nw);
                if (k == 0) begin
                    m_act[k] = 1; m_trk[k] = pcode(nw); m_pt[k] = t;
                end
            end else if (m_act[k] && pcode(m_st) != m_trk[k]) begin
                m_act[k] = 0;
            end else if (m_act[k]) begin
                d = t - m_pt[k];
                if (d >= RD && (d - RD) % RP == 0) begin
                    m_v[k] = 1; m_rep[k] = 1; m_ec[k] = m_trk[k];
                end
            end
        end
        for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_r2;
        ns = m_st;
        for (int i = 0; i < NB; i++) begin
            all_diff = 1;
            for (int j = 0; j < DC; j++) if (m_hist[j][i] == m_st[i]) all_diff = 0;
            if (all_diff) ns[i] = m_r2[i];
        end
        m_stq = m_st;
        m_st  = ns;
        m_r2  = m_r1;
        m_r1  = btn_raw;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin ev[k] = 0; rp[k] = 0; end
    endtask

    task automatic step(input int n = 1);
        for (int c = 0; c < n; c++) begin
            model_edge();
            @(posedge clk);
            #1;
            chk("stable0", st0, m_st);
            chk("stable1", st1, m_st);
            chk("code0", bc0, pcode(m_st));
            chk("code1", bc1, pcode(m_st));
            chk("valid0", v0, m_v[0]);
            chk("valid1", v1, m_v[1]);
            chk("evcode0", ec0, m_ec[0]);
            chk("evcode1", ec1, m_ec[1]);
            if (m_v[0]) chk("repeat0", r0, m_rep[0]);
            if (m_v[1]) chk("repeat1", r1, m_rep[1]);
            if (v0) begin ev[0]++; if (r0) rp[0]++; end
            if (v1) begin ev[1]++; if (r1) rp[1]++; end
        end
    endtask

    task automatic wait_press();
        int k;
        k = 0;
        while (!v0 && k < 12) begin
            step(1);
            k++;
        end
        chk("wait_press", v0, 1);
    endtask

    initial begin
        model_reset();
        // Reset with all buttons held, then release.
        rst_n = 1'b0; btn_raw = 4'hF;
        #2;
        step(3);
        chk("rst_stable", st0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_evcode", ec0, 0);
        rst_n = 1'b1;
        clr();
        step(5);
        chk("t1_pre", st0, 0);
        step(1);
        chk("t1_stable6", st0, 4'hF);
        step(1);
        chk("t1_evt", v0, 1);
        chk("t1_code", ec0, 1);
        chk("t1_count", ev[1], 1);
        btn_raw = '0;
        step(14);

        // Bounce on bit 2.
        clr();
        btn_raw = 4'h4; step(1);
        btn_raw = 4'h0; step(1);
        btn_raw = 4'h4; step(1);
        btn_raw = 4'h0; step(1);
        btn_raw = 4'h4;
        step(5);
        chk("t2_pre", st0[2], 0);
        step(1);
        chk("t2_rise6", st0[2], 1);
        step(4);
        chk("t2_events", ev[0], 1);
        chk("t2_code", ec0, 3);
        chk("t2_press", r0, 0);
        btn_raw = '0;
        step(16);

        // Priority takeover and release.
        btn_raw = 4'h8;
        step(10);
        chk("t3_code4", bc0, 4);
        clr();
        btn_raw = 4'hA;
        step(8);
        chk("t3_ev", ev[1], 1);
        chk("t3_evcode", ec1, 2);
        chk("t3_code2", bc1, 2);
        clr();
        btn_raw = 4'h8;
        step(8);
        chk("t3_rel_code", bc1, 4);
        chk("t3_noev_rep", ev[0], 0);
        chk("t3_noev_norep", ev[1], 0);
        btn_raw = '0;
        step(20);

        // Auto-repeat while bit 0 held, press-only on the second instance.
        btn_raw = 4'h1;
        wait_press();
        chk("t4_press_norep", v1, 1);
        clr();
        step(20);
        chk("t4_repeats", rp[0], 5);
        chk("t4_events", ev[0], 5);
        chk("t5_norep", ev[1], 0);
        btn_raw = '0;
        step(6);
        chk("t4_fallen", st0, 0);
        clr();
        step(14);
        chk("t4_after_rel", ev[0], 0);

        // Reset in the middle of the repeat delay.
        btn_raw = 4'h1;
        wait_press();
        step(5);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", v0, 0);
        chk("t6_rst_stable", st0, 0);
        step(2);
        rst_n = 1'b1;
        clr();
        step(7);
        chk("t6_press", ev[0], 1);
        chk("t6_press_rep", rp[0], 0);
        clr();
        step(8);
        chk("t6_first_rep", rp[0], 1);
        btn_raw = '0;
        step(12);

        // Random traffic with occasional resets and glitches.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            btn_raw = NB'($urandom);
            step($urandom_range(1, 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
